// File: rtl/evict_write_buffer.sv
// evict_write_buffer: posted write buffer holding dirty victim lines between the
// L1 data cache and physical memory, drained one line at a time over the
// level-held pmem_write/pmem_resp handshake.
// Optional feature macro EVICT_WB_FORWARD_EN: read-miss lookup forwarding plus
// push coalescing. Without it, lookup outputs are 0 and every push allocates.
module evict_write_buffer #(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_valid,
    output logic         push_ready,
    input  logic [15:0]  push_addr,
    input  logic [127:0] push_data,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic         pmem_resp,
    input  logic [15:0]  lookup_addr,
    output logic         lookup_hit,
    output logic [127:0] lookup_data,
    output logic         empty
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = 12;
    localparam int unsigned LW = 128;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [TW-1:0]    tag_q  [DEPTH];
    logic [LW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [CW-1:0]    count_q;
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             write_q;
    logic             write_d;

    logic             push_fire;
    logic             pop;
    logic             alloc;
    logic [PW-1:0]    wr_idx;

    assign push_ready   = (count_q != CW'(DEPTH));
    assign push_fire    = push_valid & push_ready;
    assign pop          = (state_q == S_WRITE) & pmem_resp;
    assign pmem_write   = write_q;
    assign pmem_address = {tag_q[head_q], 4'h0};
    assign pmem_wdata   = data_q[head_q];
    assign empty        = (count_q == '0) && (state_q == S_IDLE);

`ifdef EVICT_WB_FORWARD_EN
    logic unused_bits;
    assign unused_bits = ^{push_addr[3:0], lookup_addr[3:0]};

    // Choose push slot: newest matching non-head line, else idle head, else tail
    always_comb begin
        logic [PW-1:0] idx;
        idx    = '0;
        wr_idx = tail_q;
        alloc  = 1'b1;
        if (valid_q[head_q] && (tag_q[head_q] == push_addr[15:4]) && (state_q != S_WRITE)) begin
            wr_idx = head_q;
            alloc  = 1'b0;
        end
        for (int unsigned k = 1; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (valid_q[idx] && (tag_q[idx] == push_addr[15:4])) begin
                wr_idx = idx;
                alloc  = 1'b0;
            end
        end
    end

    // Forwarding lookup over buffered lines, walking oldest to newest so newest wins
    always_comb begin
        logic [PW-1:0] idx;
        idx         = '0;
        lookup_hit  = 1'b0;
        lookup_data = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (valid_q[idx] && (tag_q[idx] == lookup_addr[15:4])) begin
                lookup_hit  = 1'b1;
                lookup_data = data_q[idx];
            end
        end
    end
`else
    logic unused_bits;
    assign unused_bits = ^{push_addr[3:0], lookup_addr};

    // Every push allocates at the tail; no forwarding path
    assign wr_idx      = tail_q;
    assign alloc       = 1'b1;
    assign lookup_hit  = 1'b0;
    assign lookup_data = '0;
`endif

    // Drain FSM next-state: IDLE -> WRITE -> GAP -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if ((count_q != '0) || push_fire) state_d = S_WRITE;
            S_WRITE: if (pmem_resp) state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign write_d = (state_d == S_WRITE);

    // FSM state and registered write request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
        end
    end

    // Head/tail pointers and occupancy; coalesced pushes do not move the tail
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop) head_q <= head_q + PW'(1);
            if (push_fire && alloc) tail_q <= tail_q + PW'(1);
            case ({push_fire && alloc, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Line storage: write on push, invalidate head on completed drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (pop) valid_q[head_q] <= 1'b0;
            if (push_fire) begin
                valid_q[wr_idx] <= 1'b1;
                tag_q[wr_idx]   <= push_addr[15:4];
                data_q[wr_idx]  <= push_data;
            end
        end
    end

endmodule

// File: tb/tb_evict_write_buffer.sv
// tb_evict_write_buffer: table vectors for single-line transactions plus
// hand-written fill/stress/forwarding/reset sequences; a queue scoreboard holds
// the expected pmem writes and a pmem responder pops and compares them.
`timescale 1ns/1ps
module tb_evict_write_buffer;
    localparam int unsigned DEPTH = 4;
`ifdef EVICT_WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         push_valid;
    logic         push_ready;
    logic [15:0]  push_addr;
    logic [127:0] push_data;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic         pmem_resp;
    logic [15:0]  lookup_addr;
    logic         lookup_hit;
    logic [127:0] lookup_data;
    logic         empty;

    typedef struct packed {
        logic [15:0]  addr;
        logic [127:0] data;
    } wr_t;

    typedef struct {
        logic [15:0]  addr;
        logic [127:0] data;
        logic [15:0]  lk;
        logic         hit;
        int           lat;
    } vec_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    bit  stall;
    int  resp_lat;

    evict_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_valid   (push_valid),
        .push_ready   (push_ready),
        .push_addr    (push_addr),
        .push_data    (push_data),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .lookup_addr  (lookup_addr),
        .lookup_hit   (lookup_hit),
        .lookup_data  (lookup_data),
        .empty        (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Hold push_valid until the registered push_ready allows the push, then one edge
    task automatic push_wait(input logic [15:0] a, input logic [127:0] d, input bit sb);
        int guard;
        guard = 0;
        push_valid = 1'b1;
        push_addr  = a;
        push_data  = d;
        while (!push_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!push_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL push_timeout: push_ready stuck at %0b expected 1", push_ready);
        end
        if (sb) exp_q.push_back('{addr: {a[15:4], 4'h0}, data: d});
        @(posedge clk);
        #1;
        push_valid = 1'b0;
    endtask

    // Drive push_valid for exactly one edge regardless of push_ready
    task automatic push_raw(input logic [15:0] a, input logic [127:0] d);
        push_valid = 1'b1;
        push_addr  = a;
        push_data  = d;
        @(posedge clk);
        #1;
        push_valid = 1'b0;
    endtask

    task automatic wait_empty(inout int cyc);
        while (!empty && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        if (!empty) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: empty is %0b expected 1", empty);
        end
    endtask

    // pmem model: respond after resp_lat extra cycles of pmem_write, check head vs scoreboard
    initial begin
        int  wait_cnt;
        wr_t e;
        wait_cnt  = 0;
        pmem_resp = 1'b0;
        forever begin
            @(negedge clk);
            if (pmem_resp) begin
                pmem_resp = 1'b0;
            end else if (pmem_write && rst_n && !stall) begin
                if (wait_cnt >= resp_lat) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_write: addr %h with no expected entry", pmem_address);
                    end else begin
                        e = exp_q.pop_front();
                        check("drain_addr", 128'(pmem_address), 128'(e.addr));
                        check("drain_data", pmem_wdata, e.data);
                    end
                    pmem_resp = 1'b1;
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end else if (!pmem_write) begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs[5];
        int           cyc;
        logic         exp_hit;
        logic [127:0] d1, d2, d3, d4, d5;

        vecs[0] = '{addr: 16'h1230, data: {16{8'hA5}},                      lk: 16'h1230, hit: 1'b1, lat: 0};
        vecs[1] = '{addr: 16'h123F, data: {4{32'hDEADBEEF}},                lk: 16'h1234, hit: 1'b1, lat: 3};
        vecs[2] = '{addr: 16'hFFF7, data: {2{64'h0123_4567_89AB_CDEF}},     lk: 16'hFFF0, hit: 1'b1, lat: 1};
        vecs[3] = '{addr: 16'h0000, data: {8{16'h5A3C}},                    lk: 16'h0010, hit: 1'b0, lat: 2};
        vecs[4] = '{addr: 16'hBEE5, data: 128'h1,                           lk: 16'hBEEF, hit: 1'b1, lat: 5};

        rst_n       = 1'b0;
        push_valid  = 1'b0;
        push_addr   = '0;
        push_data   = '0;
        lookup_addr = '0;
        stall       = 1'b0;
        resp_lat    = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_pmem_write", 128'(pmem_write), 128'(0));
        check("rst_pmem_address", 128'(pmem_address), 128'(0));
        check("rst_pmem_wdata", pmem_wdata, 128'(0));
        check("rst_push_ready", 128'(push_ready), 128'(1));
        check("rst_lookup_hit", 128'(lookup_hit), 128'(0));
        check("rst_lookup_data", lookup_data, 128'(0));
        check("rst_empty", 128'(empty), 128'(1));

        // Table: single line into an empty buffer, checked at push+1 and at drain end
        for (int i = 0; i < 5; i++) begin
            resp_lat    = vecs[i].lat;
            lookup_addr = vecs[i].lk;
            push_wait(vecs[i].addr, vecs[i].data, 1'b1);
            @(negedge clk);
            exp_hit = FWD && vecs[i].hit;
            check("vec_write_rise", 128'(pmem_write), 128'(1));
            check("vec_addr", 128'(pmem_address), 128'({vecs[i].addr[15:4], 4'h0}));
            check("vec_wdata", pmem_wdata, vecs[i].data);
            check("vec_lookup_hit", 128'(lookup_hit), 128'(exp_hit));
            check("vec_lookup_data", lookup_data, exp_hit ? vecs[i].data : 128'(0));
            check("vec_empty_low", 128'(empty), 128'(0));
            cyc = 1;
            wait_empty(cyc);
            check("vec_drain_cycles", 128'(cyc), 128'(vecs[i].lat + 3));
        end

        // Fill to DEPTH with pmem stalled, then drain in FIFO order
        stall = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            push_wait(16'(16'h8000 + i * 16), {4{32'(i + 32'hC0DE_0000)}}, 1'b1);
        end
        check("full_not_ready", 128'(push_ready), 128'(0));
        push_raw(16'h9000, {4{32'hBAD0_BAD0}});
        check("full_push_ignored_ready", 128'(push_ready), 128'(0));
        check("full_head_addr_stable", 128'(pmem_address), 128'(16'h8000));
        resp_lat = 1;
        stall    = 1'b0;
        cyc      = 0;
        while (cyc < 50) begin
            @(negedge clk);
            #2;
            if (pmem_resp) break;
            cyc++;
        end
        check("resp_seen", 128'(pmem_resp), 128'(1));
        check("ready_low_at_pop", 128'(push_ready), 128'(0));
        @(negedge clk);
        #2;
        check("ready_after_pop", 128'(push_ready), 128'(1));
        cyc = 0;
        wait_empty(cyc);
        check("fill_all_drained", 128'(exp_q.size()), 128'(0));

        // Back-to-back pushes while draining: pointer wrap, simultaneous push/pop
        resp_lat = 0;
        for (int i = 0; i < 9; i++) begin
            push_wait(16'(16'h6000 + i * 16), {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        end
        cyc = 0;
        wait_empty(cyc);
        check("stress_all_drained", 128'(exp_q.size()), 128'(0));

`ifdef EVICT_WB_FORWARD_EN
        // Forwarding: duplicate of the head being written gets a new entry, newest wins
        d1 = {4{32'h1111_0001}};
        d2 = {4{32'h2222_0002}};
        d3 = {4{32'h3333_0003}};
        stall = 1'b1;
        push_wait(16'h4000, d1, 1'b1);
        push_wait(16'h5000, d2, 1'b1);
        push_wait(16'h4000, d3, 1'b1);
        lookup_addr = 16'h400C;
        #1;
        check("fwd_hit", 128'(lookup_hit), 128'(1));
        check("fwd_newest", lookup_data, d3);
        lookup_addr = 16'h5008;
        #1;
        check("fwd_hit2", 128'(lookup_hit), 128'(1));
        check("fwd_data2", lookup_data, d2);
        check("fwd_head_wdata", pmem_wdata, d1);
        resp_lat = 2;
        stall    = 1'b0;
        cyc = 0;
        wait_empty(cyc);
        check("fwd_all_drained", 128'(exp_q.size()), 128'(0));

        // Coalescing into a non-head entry keeps count unchanged
        d4 = {4{32'h4444_0004}};
        d5 = {4{32'h5555_0005}};
        stall = 1'b1;
        push_wait(16'h2000, d1, 1'b1);
        push_wait(16'h3000, d2, 1'b0);
        push_wait(16'h3000, d4, 1'b1);
        push_wait(16'h7000, d5, 1'b1);
        lookup_addr = 16'h3000;
        #1;
        check("coal_ready_count3", 128'(push_ready), 128'(1));
        check("coal_lookup", lookup_data, d4);
        resp_lat = 1;
        stall    = 1'b0;
        cyc = 0;
        wait_empty(cyc);
        check("coal_all_drained", 128'(exp_q.size()), 128'(0));
`else
        d1 = '0; d2 = '0; d3 = '0; d4 = '0; d5 = '0;
`endif

        // Asynchronous reset in the middle of a write
        stall       = 1'b1;
        lookup_addr = 16'hA000;
        push_wait(16'hA000, {4{32'hFEED_FACE}}, 1'b1);
        @(negedge clk);
        check("rstw_write_high", 128'(pmem_write), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("rstw_write_drop", 128'(pmem_write), 128'(0));
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstw_empty", 128'(empty), 128'(1));
        check("rstw_lookup_hit", 128'(lookup_hit), 128'(0));
        check("rstw_ready", 128'(push_ready), 128'(1));
        check("rstw_write_low", 128'(pmem_write), 128'(0));
        stall = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/evict_write_buffer.md
# evict_write_buffer

Posted write buffer between the L1 data cache and physical memory. It accepts dirty 128-bit victim lines from the cache controller, after store data has been merged into the line by the byte-insert stage. It drains the lines to pmem one at a time using the level-held `pmem_write`/`pmem_resp` handshake. Optionally it forwards buffered lines to the cache on a read-miss lookup, so a miss never reads stale pmem.

## Interface
- `DEPTH`, default 2: number of line entries; power of two, range 2..8.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `push_valid`  in  1: cache presents a victim line.
- `push_ready`  out  1: buffer accepts the line; equals `count != DEPTH`.
- `push_addr`  in  16: line address; bits [3:0] are ignored and stored as 0.
- `push_data`  in  128: victim line (`lc3b_pmem_line`).
- `pmem_write`  out  1: write request to pmem; held high until `pmem_resp`.
- `pmem_address`  out  16: address of the head entry, with [3:0] = 0.
- `pmem_wdata`  out  128: data of the head entry.
- `pmem_resp`  in  1: pmem completion; sampled only while `pmem_write` = 1.
- `lookup_addr`  in  16: cache miss address; bits [3:0] are ignored.
- `lookup_hit`  out  1: a buffered entry matches `lookup_addr[15:4]`.
- `lookup_data`  out  128: line data of the matching entry.
- `empty`  out  1: `count == 0` and the FSM is in IDLE.

## Operation
- Storage is a circular FIFO of {addr[15:4], data[127:0], valid}, with head pointer, tail pointer and `count` (width clog2(DEPTH)+1).
- Push fires when `push_valid & push_ready`.
- Coalescing on push:
  - If a valid non-head entry has the same addr[15:4], its data is overwritten in place; tail and count are unchanged.
  - If the only match is the head while the FSM is in WRITE, a new entry is allocated.
  - If the head matches while the FSM is IDLE or GAP, the head is overwritten in place.
- Drain FSM states: IDLE, WRITE, GAP.
  - IDLE -> WRITE when `count > 0`.
  - WRITE holds `pmem_write` = 1 with the head's address and data, which stay stable for the whole WRITE. On `pmem_resp`, the head is popped (valid cleared, head+1, count-1) and the FSM goes to GAP.
  - GAP lasts one cycle with `pmem_write` = 0, then goes to IDLE.
- Push and pop in the same cycle: count is unchanged, both pointers advance.
- `push_ready` comes from the registered count, so it stays 0 when the buffer is full, even in a cycle where a pop occurs.
- Lookup is purely combinational over valid entries, including the head during WRITE. When several entries match, the newest (closest to tail) wins. Lookup sees contents from before any same-cycle push.
- Pointer wrap: pointers are modulo DEPTH.

## Timing
- Reset values: `pmem_write` = 0, `pmem_address` = 0, `pmem_wdata` = 0, `push_ready` = 1, `lookup_hit` = 0, `lookup_data` = 0, `empty` = 1; all valid bits 0; pointers 0; FSM in IDLE.
- Reset is asynchronous. Asserting `rst_n` mid-WRITE drops `pmem_write` immediately and discards all entries.
- Push into an empty buffer at edge N: `pmem_write` = 1 from cycle N+1.
- `pmem_resp` at edge M: `pmem_write` = 0 in cycle M+1 (GAP) and cycle M+2 (IDLE). The next entry's write starts at cycle M+3.
- Per-line drain cost is therefore (pmem latency + 2) cycles.
- `lookup_hit` and `lookup_data` follow `lookup_addr` in the same cycle. A line pushed at edge N is visible to lookup from cycle N+1.

## Configuration
- Macro: `EVICT_WB_FORWARD_EN`.
- Defined: lookup port operates as described above.
- Undefined:
  - `lookup_hit` is tied to 0 and `lookup_data` to 0; the compare logic is removed.
  - Coalescing is also disabled: every push allocates a new entry.
  - The cache controller must wait for `empty` before issuing any pmem read.

## Test plan
- Single push of addr 0x1230, data 128'hA5..A5:
  - `pmem_write` rises one cycle later with `pmem_address` 0x1230.
  - After `pmem_resp`, `empty` = 1 two cycles later.
- Fill to DEPTH with pmem stalled: `push_ready` = 0.
  - A push attempt while full is ignored.
  - On the first `pmem_resp`, `push_ready` returns to 1 the next cycle.
  - Entries drain in FIFO order.
- Forwarding (macro on): push 0x4000 data D1, then 0x5000 D2, then 0x4000 D3 while the head is in WRITE.
  - `lookup_addr` 0x400C returns `lookup_hit` = 1 with D3.
  - pmem receives D1, D2, D3 in that order.
- Coalescing: push 0x2000 D1 and 0x3000 D2 with the head in WRITE, then push 0x3000 D4.
  - count stays 2.
  - pmem sees 0x2000 D1, then 0x3000 D4.
- Reset mid-write: drop `rst_n` while `pmem_write` = 1.
  - `pmem_write` = 0 in the same cycle.
  - After release: `empty` = 1 and `lookup_hit` = 0.
- Macro off: with a pushed line matching `lookup_addr`, `lookup_hit` stays 0 and `empty` = 0 until the drain completes.
